// File: rtl/div_stall_unit.sv
// ============================================================================
// div_stall_unit : 32-cycle radix-2 restoring divider with EX stall request
// Optional macro DIV_SIGNED_EN enables signed divide.  Rev 1.0
// ============================================================================
`default_nettype none

module div_stall_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq_for_ex
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_quot, r_rem, r_dvsr;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_dd_mag, w_dv_mag;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx, w_quot_nx, w_rem_fin, w_quot_fin;
  logic               w_accept, w_divzero;

  assign w_divzero = (divisor == '0);
  assign w_accept  = (r_state == S_IDLE) & start & ~annul;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign w_shift   = {r_rem, r_quot[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvsr});
  assign w_rem_nx  = w_ge ? WIDTH'(w_shift - {1'b0, r_dvsr}) : w_shift[WIDTH-1:0];
  assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

`ifdef DIV_SIGNED_EN
  logic w_dd_neg, w_dv_neg;
  logic r_neg_q, r_neg_r;

  assign w_dd_neg   = signed_div & dividend[WIDTH-1];
  assign w_dv_neg   = signed_div & divisor[WIDTH-1];
  assign w_dd_mag   = w_dd_neg ? -dividend : dividend;
  assign w_dv_mag   = w_dv_neg ? -divisor  : divisor;
  assign w_quot_fin = r_neg_q ? -w_quot_nx : w_quot_nx;
  assign w_rem_fin  = r_neg_r ? -w_rem_nx  : w_rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_dd_neg ^ w_dv_neg;
      r_neg_r <= w_dd_neg;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_div;
  assign w_dd_mag        = dividend;
  assign w_dv_mag        = divisor;
  assign w_quot_fin      = w_quot_nx;
  assign w_rem_fin       = w_rem_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = w_divzero ? S_DIVZERO : S_ON;
      S_ON:      if (r_cnt == C_LAST) w_next = S_DONE;
      S_DIVZERO: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (annul) w_next = S_IDLE;
  end

  // For a zero divisor r_quot keeps the raw dividend for the DIVZERO result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_quot <= w_divzero ? dividend : w_dd_mag;
      r_dvsr <= w_dv_mag;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_ON && !annul) begin
      r_quot <= w_quot_nx;
      r_rem  <= w_rem_nx;
      r_cnt  <= r_cnt + CW'(1);
      if (r_cnt == C_LAST) r_result <= {w_rem_fin, w_quot_fin};
    end else if (r_state == S_DIVZERO && !annul) begin
      r_result <= {r_quot, {WIDTH{1'b1}}};
    end
  end

  assign result          = r_result;
  assign ready           = (r_state == S_DONE);
  assign stallreq_for_ex = start & ~annul & (r_state != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_div_stall_unit.sv
// ============================================================================
// tb_div_stall_unit : directed self-checking bench for div_stall_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_for_ex;

  int errors = 0;
  int checks = 0;

  div_stall_unit #(.WIDTH(32)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .signed_div      (signed_div),
    .dividend        (dividend),
    .divisor         (divisor),
    .annul           (annul),
    .result          (result),
    .ready           (ready),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start one divide, hold start until ready, then check latency/stall/result.
  task automatic do_div(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                        input logic sg, input logic [63:0] exp_res, input int exp_lat);
    int   n;
    logic stall_ok;
    @(posedge clk); #1;
    start = 1'b1; dividend = dd; divisor = dv; signed_div = sg;
    #1;
    chk({tag, " stall_at_start"}, stallreq_for_ex, 1);
    n = 0;
    stall_ok = 1'b1;
    while (!ready && n < 40) begin
      @(posedge clk); #2;
      n++;
      if (!ready && !stallreq_for_ex) stall_ok = 1'b0;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " stall_held"}, stall_ok, 1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " stall_in_done"}, stallreq_for_ex, 0);
    start = 1'b0; dividend = '0; divisor = '0; signed_div = 1'b0;
    @(posedge clk); #2;
    chk({tag, " ready_drop"}, ready, 0);
    chk({tag, " result_held"}, result, exp_res);
  endtask

  task automatic watch_no_ready(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (ready) seen++;
    end
    chk({tag, " no_ready"}, seen, 0);
  endtask

  initial begin
    #2;
    chk("reset result", result, 64'd0);
    chk("reset ready", ready, 0);
    chk("reset stall", stallreq_for_ex, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_div("u100/7",  32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    do_div("u5/0",    32'd5,   32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 2);
    do_div("u0/5",    32'd0,   32'd5, 1'b0, 64'd0, 33);
    do_div("u7/9",    32'd7,   32'd9, 1'b0, {32'd7, 32'd0}, 33);
    do_div("umax/1",  32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33);
    do_div("umax/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'd1}, 33);
`ifdef DIV_SIGNED_EN
    do_div("s-7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33);
    do_div("s7/-2",   32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33);
    do_div("s-7/0",   32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 2);
`else
    do_div("ign-7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, {32'd1, 32'h7FFF_FFFC}, 33);
    do_div("ignmin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'd0}, 33);
`endif

    // Annul in the middle of an operation.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    #1;
    chk("annul stall_low", stallreq_for_ex, 0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    #1;
    chk("annul idle_stall", stallreq_for_ex, 0);
    chk("annul ready", ready, 0);
    watch_no_ready("annul");
    do_div("after_annul 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("rst result", result, 64'd0);
    chk("rst ready", ready, 0);
    chk("rst stall", stallreq_for_ex, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_ready("rst");
    do_div("after_rst 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
